// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared RISC-V definitions: immediate-format selector encodings (common to
//   the immediate-extend unit and imm_encoder), base opcodes, and the
//   imm_encoder output-buffer entry layout.
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } fifo_ent_t;

endpackage

// File: rtl/imm_pack.sv
// ----------------------------------------------------------------------------
// imm_pack
//   Combinational immediate packer: scatters Imm into the I/S/B/U/J field
//   positions of Base (Base's immediate bits replaced) and flags values that
//   the selected format cannot represent.
// Ports
//   src_i    immediate format selector
//   imm_i    immediate value (byte offset for B/J)
//   base_i   instruction word supplying opcode/funct/register fields
//   instr_o  packed instruction word (base_i unchanged for an illegal src_i)
//   err_o    out of range, misaligned, or illegal src_i
// ----------------------------------------------------------------------------
import riscv_pkg::*;

module imm_pack (
  input  imm_src_t    src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // An N-bit signed value fits when bits [31:N-1] are all equal.
  logic fits12, fits13, fits21;

  assign fits12 = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) || !(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) || !(|imm_i[31:20]);

  always_comb begin
    instr_o = base_i;
    err_o   = 1'b1;
    case (src_i)
      IMM_I: begin
        instr_o = {imm_i[11:0], base_i[19:0]};
        err_o   = !fits12;
      end
      IMM_S: begin
        instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
        err_o   = !fits12;
      end
      IMM_B: begin
        instr_o = {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1], imm_i[11], base_i[6:0]};
        err_o   = !fits13 || imm_i[0];
      end
      IMM_U: begin
        instr_o = {imm_i[31:12], base_i[11:0]};
        err_o   = |imm_i[11:0];
      end
      IMM_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
        err_o   = !fits21 || imm_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// ----------------------------------------------------------------------------
// imm_encoder
//   Packs immediates into RISC-V instruction words and queues them, tagged with
//   a running byte address, in a 2-entry in-order output buffer.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake; in_ready depends on buffer state only
//   ImmSrc, Imm, Base     format select, immediate value, base instruction word
//   out_valid / out_ready output handshake for the buffer head
//   Instr, WrAddr, ImmErr buffer head: word, byte address, immediate-error flag
//   InstrCount            words pushed into the buffer (saturating)
//   ErrCount              erroneous requests accepted (saturating)
// ----------------------------------------------------------------------------
import riscv_pkg::*;

module imm_encoder #(
  parameter int unsigned ADDR_W   = 8,
  parameter bit          DROP_ERR = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ImmSrc,
  input  logic [31:0]       Imm,
  input  logic [31:0]       Base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] WrAddr,
  output logic              ImmErr,
  output logic [CNT_W-1:0]  InstrCount,
  output logic [CNT_W-1:0]  ErrCount
);

  logic [31:0] enc_instr;
  logic        enc_err;

  imm_pack u_pack (
    .src_i   (imm_src_t'(ImmSrc)),
    .imm_i   (Imm),
    .base_i  (Base),
    .instr_o (enc_instr),
    .err_o   (enc_err)
  );

  fifo_ent_t         ent_q  [2];
  logic [ADDR_W-1:0] eaddr_q[2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic              accept, push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (!enc_err || !DROP_ERR);
  assign pop       = out_valid && out_ready;

  assign Instr      = ent_q[rd_ptr_q].instr;
  assign ImmErr     = ent_q[rd_ptr_q].err;
  assign WrAddr     = eaddr_q[rd_ptr_q];
  assign InstrCount = icnt_q;
  assign ErrCount   = ecnt_q;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    addr_d  = addr_q;
    icnt_d  = icnt_q;
    ecnt_d  = ecnt_q;
    if (push) begin
      addr_d = addr_q + ADDR_W'(4);  // wraps modulo 2**ADDR_W
      if (!(&icnt_q)) icnt_d = icnt_q + CNT_W'(1);
    end
    if (accept && enc_err && !(&ecnt_q)) ecnt_d = ecnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        ent_q[i]   <= '0;
        eaddr_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      addr_q   <= '0;
      icnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q]   <= '{instr: enc_instr, err: enc_err};
        eaddr_q[wr_ptr_q] <= addr_q;
        wr_ptr_q          <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_d;
      addr_q  <= addr_d;
      icnt_q  <= icnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
import riscv_pkg::*;

module tb_imm_encoder;

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  ImmSrc = '0;
  logic [31:0] Imm = '0, Base = '0;

  logic          rdy0, ov0, err0, rdy1, ov1, err1;
  logic [31:0]   ins0, ins1;
  logic [AW-1:0] wa0, wa1;
  logic [CW-1:0] ic0, ec0, ic1, ec1;

  imm_encoder #(.ADDR_W(AW), .DROP_ERR(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .ImmSrc(ImmSrc),
    .Imm(Imm), .Base(Base), .out_valid(ov0), .out_ready(out_ready), .Instr(ins0),
    .WrAddr(wa0), .ImmErr(err0), .InstrCount(ic0), .ErrCount(ec0));

  imm_encoder #(.ADDR_W(AW), .DROP_ERR(1'b1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .ImmSrc(ImmSrc),
    .Imm(Imm), .Base(Base), .out_valid(ov1), .out_ready(out_ready), .Instr(ins1),
    .WrAddr(wa1), .ImmErr(err1), .InstrCount(ic1), .ErrCount(ec1));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
  } ment_t;

  ment_t       mq0[$];
  ment_t       mq1[$];
  logic [31:0] maddr[2];
  logic [31:0] mic[2];
  logic [31:0] mec[2];

  // Instruction bit p holds immediate bit imm_idx(s,p); -1 means a Base bit.
  function automatic int imm_idx(input logic [2:0] s, input int p);
    case (s)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: return (p >= 25) ? p - 20 : ((p >= 7 && p <= 11) ? p - 7 : -1);
      3'd2: begin
        if (p == 31) return 12;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      3'd3: return (p >= 12) ? p : -1;
      3'd4: begin
        if (p == 31) return 20;
        if (p >= 21) return p - 20;
        if (p == 20) return 11;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input logic [2:0] s, input logic [31:0] imm,
                                            input logic [31:0] base, output bit ok);
    int v;
    logic [31:0] r;
    v = $signed(imm);
    case (s)
      3'd0, 3'd1: ok = (v >= -2048) && (v <= 2047);
      3'd2:       ok = (v >= -4096) && (v <= 4095) && (imm % 2 == 0);
      3'd3:       ok = (imm % 4096 == 0);
      3'd4:       ok = (v >= -1048576) && (v <= 1048575) && (imm % 2 == 0);
      default:    ok = 1'b0;
    endcase
    r = base;
    for (int p = 0; p < 32; p++) begin
      int k;
      k = imm_idx(s, p);
      if (k >= 0) r[p] = imm[k];
    end
    return r;
  endfunction

  // Independent decoder (the extend unit) for the roundtrip check.
  function automatic logic [31:0] extend(input logic [2:0] s, input logic [31:0] w);
    case (s)
      3'd0: return {{20{w[31]}}, w[31:20]};
      3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: return {w[31:12], 12'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit    ok, acc, push;
    int    sz;
    ment_t m;
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      for (int d = 0; d < 2; d++) begin
        maddr[d] <= 0;
        mic[d]   <= 0;
        mec[d]   <= 0;
      end
    end else begin
      m.instr = model_enc(ImmSrc, Imm, Base, ok);
      m.err   = !ok;
      m.src   = ImmSrc;
      m.imm   = Imm;
      for (int d = 0; d < 2; d++) begin
        sz  = (d == 0) ? mq0.size() : mq1.size();
        acc = in_valid && (sz != 2);
        if (out_ready && sz != 0) begin
          if (d == 0) void'(mq0.pop_front());
          else        void'(mq1.pop_front());
        end
        push = acc && (ok || d == 0);
        if (push) begin
          m.addr = maddr[d];
          if (d == 0) mq0.push_back(m);
          else        mq1.push_back(m);
          maddr[d] <= (maddr[d] + 4) % (1 << AW);
          if (mic[d] < (1 << CW) - 1) mic[d] <= mic[d] + 1;
        end
        if (acc && !ok && mec[d] < (1 << CW) - 1) mec[d] <= mec[d] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("rdy0", 32'(rdy0), 32'(mq0.size() != 2));
      chk("rdy1", 32'(rdy1), 32'(mq1.size() != 2));
      chk("ov0", 32'(ov0), 32'(mq0.size() != 0));
      chk("ov1", 32'(ov1), 32'(mq1.size() != 0));
      chk("icnt0", 32'(ic0), mic[0]);
      chk("icnt1", 32'(ic1), mic[1]);
      chk("ecnt0", 32'(ec0), mec[0]);
      chk("ecnt1", 32'(ec1), mec[1]);
      if (ov0 && mq0.size() != 0) begin
        chk("instr0", ins0, mq0[0].instr);
        chk("addr0", 32'(wa0), mq0[0].addr);
        chk("err0", 32'(err0), 32'(mq0[0].err));
        if (!mq0[0].err) chk("roundtrip", extend(mq0[0].src, ins0), mq0[0].imm);
      end
      if (ov1 && mq1.size() != 0) begin
        chk("instr1", ins1, mq1[0].instr);
        chk("addr1", 32'(wa1), mq1[0].addr);
        chk("err1", 32'(err1), 32'(mq1[0].err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [2:0] s, input logic [31:0] imm, input logic [31:0] base);
    @(negedge clk);
    in_valid = 1'b1; ImmSrc = s; Imm = imm; Base = base;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] bnd[12];

  initial begin
    bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
            32'hFFFFF000, 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'h00000FFF, 32'd1};

    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(ov0), 32'd0);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_instr", ins0, 32'd0);
    chk("rst_addr", 32'(wa0), 32'd0);
    chk("rst_cnt", 32'({ic0, ec0}), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Directed vectors (out_ready=1, so each word is head for one cycle)
    do_req(3'd0, 32'hFFFFF800, 32'h00000013);
    chk("lit_I", ins0, 32'h80000013); chk("lit_I_err", 32'(err0), 32'd0); chk("lit_I_addr", 32'(wa0), 32'h00);
    do_req(3'd1, 32'hFFFFFAB5, 32'h00002023);
    chk("lit_S", ins0, 32'hAA002AA3); chk("lit_S_addr", 32'(wa0), 32'h04);
    do_req(3'd3, 32'hAAAAA000, 32'h00000037);
    chk("lit_U", ins0, 32'hAAAAA037);
    do_req(3'd4, 32'hFFF00000, {25'd0, OPC_JAL});
    chk("lit_J", ins0, 32'h8000006F); chk("lit_J_addr", 32'(wa0), 32'h0C);

    // Error requests: emitted by dut0, dropped by dut1
    do_req(3'd2, 32'h00000003, {25'd0, OPC_BRANCH});
    chk("lit_Bmis_err", 32'(err0), 32'd1); chk("lit_Bmis_addr", 32'(wa0), 32'h10);
    chk("lit_drop_ov", 32'(ov1), 32'd0);
    do_req(3'd2, 32'h00001000, {25'd0, OPC_BRANCH});
    chk("lit_Brng_err", 32'(err0), 32'd1);
    do_req(3'd7, 32'h00000000, 32'h12345678);
    chk("lit_ill", ins0, 32'h12345678); chk("lit_ill_err", 32'(err0), 32'd1);
    chk("lit_ecnt0", 32'(ec0), 32'd3); chk("lit_ecnt1", 32'(ec1), 32'd3);
    chk("lit_icnt0", 32'(ic0), 32'd7); chk("lit_icnt1", 32'(ic1), 32'd4);
    do_req(3'd0, 32'd0, {25'd0, OPC_OP_IMM});
    chk("lit_drop_addr", 32'(wa1), 32'h10); chk("lit_keep_addr", 32'(wa0), 32'h1C);

    // Backpressure: three requests with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; ImmSrc = 3'd0; Base = 32'h13; Imm = 32'd1;
    @(negedge clk); Imm = 32'd2;
    @(negedge clk); Imm = 32'd3;
    @(negedge clk);
    chk("bp_rdy", 32'(rdy0), 32'd0); chk("bp_head", ins0, 32'h00100013);
    repeat (2) @(negedge clk);
    chk("bp_hold_rdy", 32'(rdy0), 32'd0); chk("bp_hold_head", ins0, 32'h00100013);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 32'(rdy0), 32'd1); chk("bp_B", ins0, 32'h00200013);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_C", ins0, 32'h00300013);
    @(negedge clk);
    chk("bp_empty", 32'(ov0), 32'd0);

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i == 1500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", 32'(ov0), 32'd0);
        chk("mid_rst_addr", 32'(wa0), 32'd0);
        chk("mid_rst_ov1", 32'(ov1), 32'd0);
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 200 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      ImmSrc    = 3'($urandom_range(0, 7));
      Base      = $urandom;
      r         = $urandom_range(0, 7);
      if (r < 5) begin
        case (ImmSrc)
          3'd0, 3'd1: Imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          3'd2:       Imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
          3'd3:       Imm = $urandom & 32'hFFFFF000;
          3'd4:       Imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
          default:    Imm = $urandom;
        endcase
      end else if (r < 7) begin
        Imm = bnd[$urandom_range(0, 11)];
      end else begin
        Imm = $urandom;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
